// File: rtl/instr_fetcher_if.sv
// instr_fetcher_if
//   Bundles the fetch stage's memory port, decoder port, issue handshake and
//   PC redirect port.
//   master : the fetch stage (drives mem_rd/mem_addr, dec_*, insn_*, pc)
//   slave  : the surroundings (memory, decoder, execute, redirect source)
interface instr_fetcher_if;
   logic        mem_rd;
   logic [15:0] mem_addr;
   logic        mem_ready;
   logic [7:0]  mem_data;
   logic [15:0] dec_instr;
   logic [1:0]  dec_instr_len;
   logic [7:0]  dec_group;
   logic        insn_valid;
   logic [7:0]  insn_group;
   logic [15:0] insn_opcode;
   logic [1:0]  insn_len;
   logic        insn_illegal;
   logic        insn_ack;
   logic [15:0] pc;
   logic        pc_load;
   logic [15:0] pc_in;

   modport master (
      output mem_rd, mem_addr, dec_instr, dec_instr_len,
             insn_valid, insn_group, insn_opcode, insn_len, insn_illegal, pc,
      input  mem_ready, mem_data, dec_group, insn_ack, pc_load, pc_in
   );

   modport slave (
      input  mem_rd, mem_addr, dec_instr, dec_instr_len,
             insn_valid, insn_group, insn_opcode, insn_len, insn_illegal, pc,
      output mem_ready, mem_data, dec_group, insn_ack, pc_load, pc_in
   );
endinterface

// File: rtl/instr_fetcher.sv
// instr_fetcher
//   Opcode-byte fetch stage of the Z80 core. Reads opcode bytes at pc,
//   accumulates them for instr_decoder until it resolves a group, then holds
//   the resolved instruction for execute under a valid/ack handshake.
// Ports
//   clk   : system clock, all state on rising edge
//   reset : asynchronous, active-high
//   bus   : instr_fetcher_if.master
//             mem_rd/mem_addr/mem_ready/mem_data  opcode memory read port
//             dec_instr/dec_instr_len/dec_group  decoder inputs and result
//             insn_valid/group/opcode/len/illegal/ack  issue handshake
//             pc/pc_load/pc_in                  program counter and redirect
// Configuration
//   FETCH_ILLEGAL_TRAP_EN : when defined, an issued ILLEGAL_INSTR raises
//   insn_illegal and, once acknowledged, parks the fetcher in TRAP until a
//   pc_load. When undefined, illegal instructions issue like any other group
//   and insn_illegal is tied low.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | out of reset, start fetching next cycle
// FETCH  | mem_rd high, waiting for mem_ready to take one opcode byte
// DECODE | decoder sees the accumulated bytes; fetch more or resolve
// ISSUE  | insn_* held valid until execute acknowledges
// TRAP   | (trap build) illegal instruction retired, wait for pc_load
module instr_fetcher (
   input  logic        clk,
   input  logic        reset,
   instr_fetcher_if.master bus
);

   // Group codes mirrored from z80.vh.
   localparam logic [7:0] INSN_GROUP_NEED_MORE_BYTES = 8'hFE;
   localparam logic [7:0] INSN_GROUP_ILLEGAL_INSTR   = 8'hFF;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      DECODE,
`ifdef FETCH_ILLEGAL_TRAP_EN
      ISSUE,
      TRAP
`else
      ISSUE
`endif
   } state_t;

   state_t      state;
   logic        mem_rd;
   logic [15:0] pc;
   logic [15:0] dec_instr;
   logic [1:0]  dec_instr_len;
   logic        insn_valid;
   logic [7:0]  insn_group;
   logic [15:0] insn_opcode;
   logic [1:0]  insn_len;
   logic [7:0]  resolved_group;

   // A group still asking for bytes after two have been fetched (DD CB ...)
   // has no opcode this stage can deliver, so it is reported as illegal.
   always_comb begin
      resolved_group = bus.dec_group;
      if (bus.dec_group == INSN_GROUP_NEED_MORE_BYTES)
         resolved_group = INSN_GROUP_ILLEGAL_INSTR;
   end

`ifdef FETCH_ILLEGAL_TRAP_EN
   logic insn_illegal;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state         <= IDLE;
         mem_rd        <= 1'b0;
         pc            <= 16'h0000;
         dec_instr     <= 16'h0000;
         dec_instr_len <= 2'd0;
         insn_valid    <= 1'b0;
         insn_group    <= 8'h00;
         insn_opcode   <= 16'h0000;
         insn_len      <= 2'd0;
`ifdef FETCH_ILLEGAL_TRAP_EN
         insn_illegal  <= 1'b0;
`endif
      end else if (bus.pc_load) begin
         // Redirect wins over everything, including a byte or ack this cycle.
         state         <= FETCH;
         mem_rd        <= 1'b1;
         pc            <= bus.pc_in;
         dec_instr     <= 16'h0000;
         dec_instr_len <= 2'd0;
         insn_valid    <= 1'b0;
`ifdef FETCH_ILLEGAL_TRAP_EN
         insn_illegal  <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               state  <= FETCH;
               mem_rd <= 1'b1;
            end
            FETCH: begin
               if (bus.mem_ready) begin
                  if (dec_instr_len == 2'd0)
                     dec_instr[7:0]  <= bus.mem_data;
                  else
                     dec_instr[15:8] <= bus.mem_data;
                  dec_instr_len <= dec_instr_len + 2'd1;
                  pc            <= pc + 16'd1;
                  state         <= DECODE;
                  mem_rd        <= 1'b0;
               end
            end
            DECODE: begin
               if (bus.dec_group == INSN_GROUP_NEED_MORE_BYTES &&
                   dec_instr_len < 2'd2) begin
                  state  <= FETCH;
                  mem_rd <= 1'b1;
               end else begin
                  insn_group   <= resolved_group;
                  insn_opcode  <= dec_instr;
                  insn_len     <= dec_instr_len;
                  insn_valid   <= 1'b1;
`ifdef FETCH_ILLEGAL_TRAP_EN
                  insn_illegal <= (resolved_group == INSN_GROUP_ILLEGAL_INSTR);
`endif
                  state        <= ISSUE;
               end
            end
            ISSUE: begin
               if (bus.insn_ack) begin
                  insn_valid    <= 1'b0;
                  dec_instr     <= 16'h0000;
                  dec_instr_len <= 2'd0;
`ifdef FETCH_ILLEGAL_TRAP_EN
                  insn_illegal  <= 1'b0;
                  if (insn_illegal) begin
                     state  <= TRAP;
                     mem_rd <= 1'b0;
                  end else begin
                     state  <= FETCH;
                     mem_rd <= 1'b1;
                  end
`else
                  state  <= FETCH;
                  mem_rd <= 1'b1;
`endif
               end
            end
`ifdef FETCH_ILLEGAL_TRAP_EN
            TRAP: begin
               mem_rd <= 1'b0;
            end
`endif
            default: begin
               state  <= IDLE;
               mem_rd <= 1'b0;
            end
         endcase
      end
   end

   assign bus.mem_rd        = mem_rd;
   assign bus.mem_addr      = pc;
   assign bus.pc            = pc;
   assign bus.dec_instr     = dec_instr;
   assign bus.dec_instr_len = dec_instr_len;
   assign bus.insn_valid    = insn_valid;
   assign bus.insn_group    = insn_group;
   assign bus.insn_opcode   = insn_opcode;
   assign bus.insn_len      = insn_len;
`ifdef FETCH_ILLEGAL_TRAP_EN
   assign bus.insn_illegal  = insn_illegal;
`else
   assign bus.insn_illegal  = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetcher.sv
// tb_instr_fetcher
//   Directed bench for instr_fetcher: a byte-array memory and a small
//   decoder table stand in for the neighbours; each scenario task checks
//   hand-computed values cycle by cycle.
module tb_instr_fetcher;

   localparam logic [7:0] G_NEED    = 8'hFE;
   localparam logic [7:0] G_ILLEGAL = 8'hFF;
   localparam logic [7:0] G_LD_IMM  = 8'h01;
   localparam logic [7:0] G_LD_EXT  = 8'h02;
   localparam logic [7:0] G_LD_RR   = 8'h03;

   logic clk;
   logic reset;
   int   vectors;
   int   miscompares;
   logic [7:0] mem [0:65535];

   instr_fetcher_if bus ();

   instr_fetcher dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   function automatic logic [7:0] dec_model(input logic [15:0] ins,
                                            input logic [1:0] len);
      logic [7:0] g;
      g = G_ILLEGAL;
      if (len == 2'd0) g = G_NEED;
      else if (len == 2'd1) begin
         case (ins[7:0])
            8'h3E: g = G_LD_IMM;
            8'h7F: g = G_LD_RR;
            8'hED, 8'hDD, 8'hFD, 8'hCB: g = G_NEED;
            default: g = G_ILLEGAL;
         endcase
      end else begin
         case (ins)
            16'h5BED: g = G_LD_EXT;
            16'hCBDD: g = G_NEED;
            default:  g = G_ILLEGAL;
         endcase
      end
      return g;
   endfunction

   assign bus.mem_data  = mem[bus.mem_addr];
   assign bus.dec_group = dec_model(bus.dec_instr, bus.dec_instr_len);

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic load_pc(input logic [15:0] a);
      bus.pc_load = 1'b1;
      bus.pc_in   = a;
      step();
      bus.pc_load = 1'b0;
   endtask

   task automatic test_reset();
      step();
      step();
      vectors++;
      if (bus.mem_rd !== 1'b0 || bus.pc !== 16'h0000 || bus.insn_valid !== 1'b0 ||
          bus.dec_instr !== 16'h0000 || bus.dec_instr_len !== 2'd0 ||
          bus.insn_group !== 8'h00 || bus.insn_opcode !== 16'h0000 ||
          bus.insn_len !== 2'd0 || bus.insn_illegal !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_values got rd=%b pc=%h v=%b di=%h dl=%0d g=%h op=%h l=%0d ill=%b exp all zero",
                  bus.mem_rd, bus.pc, bus.insn_valid, bus.dec_instr, bus.dec_instr_len,
                  bus.insn_group, bus.insn_opcode, bus.insn_len, bus.insn_illegal);
      end
      reset = 1'b0;
   endtask

   task automatic test_single_byte();
      mem[16'h0000] = 8'h3E;
      step(); // cycle 1
      vectors++;
      if (bus.mem_rd !== 1'b1 || bus.mem_addr !== 16'h0000) begin
         miscompares++;
         $display("FAIL single_rd got rd=%b addr=%h exp 1 0000", bus.mem_rd, bus.mem_addr);
      end
      step(); // cycle 2: DECODE
      vectors++;
      if (bus.mem_rd !== 1'b0 || bus.insn_valid !== 1'b0 || bus.pc !== 16'h0001 ||
          bus.dec_instr !== 16'h003E || bus.dec_instr_len !== 2'd1) begin
         miscompares++;
         $display("FAIL single_decode got rd=%b v=%b pc=%h di=%h dl=%0d exp 0 0 0001 003e 1",
                  bus.mem_rd, bus.insn_valid, bus.pc, bus.dec_instr, bus.dec_instr_len);
      end
      step(); // cycle 3: ISSUE
      vectors++;
      if (bus.insn_valid !== 1'b1 || bus.insn_group !== G_LD_IMM ||
          bus.insn_opcode !== 16'h003E || bus.insn_len !== 2'd1 || bus.pc !== 16'h0001) begin
         miscompares++;
         $display("FAIL single_issue got v=%b g=%h op=%h l=%0d pc=%h exp 1 01 003e 1 0001",
                  bus.insn_valid, bus.insn_group, bus.insn_opcode, bus.insn_len, bus.pc);
      end
      bus.insn_ack = 1'b1;
      step();
      bus.insn_ack = 1'b0;
      vectors++;
      if (bus.insn_valid !== 1'b0 || bus.mem_rd !== 1'b1 || bus.dec_instr_len !== 2'd0 ||
          bus.dec_instr !== 16'h0000) begin
         miscompares++;
         $display("FAIL single_ack got v=%b rd=%b dl=%0d di=%h exp 0 1 0 0000",
                  bus.insn_valid, bus.mem_rd, bus.dec_instr_len, bus.dec_instr);
      end
   endtask

   task automatic test_two_byte();
      mem[16'h0100] = 8'hED;
      mem[16'h0101] = 8'h5B;
      load_pc(16'h0100); // also discards the byte presented this cycle
      vectors++;
      if (bus.pc !== 16'h0100 || bus.mem_rd !== 1'b1 || bus.dec_instr_len !== 2'd0) begin
         miscompares++;
         $display("FAIL two_load got pc=%h rd=%b dl=%0d exp 0100 1 0", bus.pc, bus.mem_rd, bus.dec_instr_len);
      end
      step(); step(); // DECODE, back to FETCH
      vectors++;
      if (bus.mem_rd !== 1'b1 || bus.mem_addr !== 16'h0101 || bus.insn_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL two_second_rd got rd=%b addr=%h v=%b exp 1 0101 0", bus.mem_rd, bus.mem_addr, bus.insn_valid);
      end
      step(); // DECODE with two bytes
      vectors++;
      if (bus.insn_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL two_early_valid got v=%b exp 0", bus.insn_valid);
      end
      step(); // N+4
      vectors++;
      if (bus.insn_valid !== 1'b1 || bus.insn_group !== G_LD_EXT ||
          bus.insn_opcode !== 16'h5BED || bus.insn_len !== 2'd2 || bus.pc !== 16'h0102) begin
         miscompares++;
         $display("FAIL two_issue got v=%b g=%h op=%h l=%0d pc=%h exp 1 02 5bed 2 0102",
                  bus.insn_valid, bus.insn_group, bus.insn_opcode, bus.insn_len, bus.pc);
      end
      bus.insn_ack = 1'b1;
      step();
      bus.insn_ack = 1'b0;
   endtask

   task automatic test_pc_load_discard();
      mem[16'h0400] = 8'hED;
      mem[16'h0401] = 8'h5B;
      mem[16'h2000] = 8'h3E;
      load_pc(16'h0400);
      step(); step(); // DECODE, FETCH for second byte
      bus.pc_load = 1'b1;
      bus.pc_in   = 16'h2000;
      step(); // mem_ready=1 concurrently
      bus.pc_load = 1'b0;
      vectors++;
      if (bus.pc !== 16'h2000 || bus.dec_instr_len !== 2'd0 || bus.dec_instr !== 16'h0000 ||
          bus.mem_rd !== 1'b1 || bus.mem_addr !== 16'h2000) begin
         miscompares++;
         $display("FAIL load_discard got pc=%h dl=%0d di=%h rd=%b addr=%h exp 2000 0 0000 1 2000",
                  bus.pc, bus.dec_instr_len, bus.dec_instr, bus.mem_rd, bus.mem_addr);
      end
      step();
      vectors++;
      if (bus.dec_instr !== 16'h003E || bus.dec_instr_len !== 2'd1 || bus.pc !== 16'h2001) begin
         miscompares++;
         $display("FAIL load_next_read got di=%h dl=%0d pc=%h exp 003e 1 2001",
                  bus.dec_instr, bus.dec_instr_len, bus.pc);
      end
      step();
      bus.insn_ack = 1'b1;
      step();
      bus.insn_ack = 1'b0;
   endtask

   task automatic test_wait_ack();
      int issues;
      mem[16'h0300] = 8'h7F;
      bus.mem_ready = 1'b0;
      load_pc(16'h0300);
      for (int i = 0; i < 3; i++) begin
         step();
         vectors++;
         if (bus.mem_rd !== 1'b1 || bus.mem_addr !== 16'h0300 || bus.dec_instr_len !== 2'd0) begin
            miscompares++;
            $display("FAIL wait_mem cyc%0d got rd=%b addr=%h dl=%0d exp 1 0300 0",
                     i, bus.mem_rd, bus.mem_addr, bus.dec_instr_len);
         end
      end
      bus.mem_ready = 1'b1;
      step(); // DECODE
      bus.mem_ready = 1'b0;
      step(); // ISSUE
      for (int i = 0; i < 5; i++) begin
         vectors++;
         if (bus.insn_valid !== 1'b1 || bus.insn_group !== G_LD_RR || bus.insn_opcode !== 16'h007F ||
             bus.insn_len !== 2'd1 || bus.mem_rd !== 1'b0 || bus.pc !== 16'h0301) begin
            miscompares++;
            $display("FAIL wait_hold cyc%0d got v=%b g=%h op=%h l=%0d rd=%b pc=%h exp 1 03 007f 1 0 0301",
                     i, bus.insn_valid, bus.insn_group, bus.insn_opcode, bus.insn_len, bus.mem_rd, bus.pc);
         end
         step();
      end
      bus.insn_ack = 1'b1;
      step();
      bus.insn_ack = 1'b0;
      issues = 0;
      for (int i = 0; i < 4; i++) begin
         if (bus.insn_valid) issues++;
         step();
      end
      vectors++;
      if (issues != 0 || bus.mem_rd !== 1'b1) begin
         miscompares++;
         $display("FAIL wait_single_issue got extra_valid=%0d rd=%b exp 0 1", issues, bus.mem_rd);
      end
      bus.mem_ready = 1'b1;
   endtask

   task automatic test_back_to_back();
      logic [7:0] seen [3];
      int n;
      mem[16'h0500] = 8'h3E;
      mem[16'h0501] = 8'h7F;
      mem[16'h0502] = 8'h3E;
      load_pc(16'h0500);
      bus.insn_ack = 1'b1; // also held outside ISSUE, where it must be ignored
      n = 0;
      for (int i = 0; i < 9; i++) begin
         step();
         if (bus.insn_valid) begin
            if (n < 3) seen[n] = bus.insn_group;
            n++;
         end
      end
      bus.insn_ack = 1'b0;
      vectors++;
      if (n != 3 || bus.pc !== 16'h0503) begin
         miscompares++;
         $display("FAIL b2b_rate got issues=%0d pc=%h exp 3 0503", n, bus.pc);
      end
      vectors++;
      if (n >= 3 && (seen[0] !== G_LD_IMM || seen[1] !== G_LD_RR || seen[2] !== G_LD_IMM)) begin
         miscompares++;
         $display("FAIL b2b_groups got %h %h %h exp 01 03 01", seen[0], seen[1], seen[2]);
      end
   endtask

   task automatic test_illegal();
      int guard;
      mem[16'h0200] = 8'hDD;
      mem[16'h0201] = 8'hCB;
      load_pc(16'h0200);
      guard = 0;
      while (bus.insn_valid !== 1'b1 && guard < 20) begin
         step();
         guard++;
      end
      vectors++;
      if (guard >= 20 || bus.insn_group !== G_ILLEGAL || bus.insn_len !== 2'd2 ||
          bus.insn_opcode !== 16'hCBDD) begin
         miscompares++;
         $display("FAIL illegal_issue got timeout=%0d g=%h l=%0d op=%h exp 0 ff 2 cbdd",
                  guard >= 20, bus.insn_group, bus.insn_len, bus.insn_opcode);
      end
`ifdef FETCH_ILLEGAL_TRAP_EN
      vectors++;
      if (bus.insn_illegal !== 1'b1) begin
         miscompares++;
         $display("FAIL illegal_flag got %b exp 1", bus.insn_illegal);
      end
      bus.insn_ack = 1'b1;
      step();
      bus.insn_ack = 1'b0;
      for (int i = 0; i < 4; i++) begin
         vectors++;
         if (bus.mem_rd !== 1'b0 || bus.insn_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL trap_hold cyc%0d got rd=%b v=%b exp 0 0", i, bus.mem_rd, bus.insn_valid);
         end
         step();
      end
      load_pc(16'h0000);
      vectors++;
      if (bus.mem_rd !== 1'b1 || bus.pc !== 16'h0000) begin
         miscompares++;
         $display("FAIL trap_exit got rd=%b pc=%h exp 1 0000", bus.mem_rd, bus.pc);
      end
`else
      vectors++;
      if (bus.insn_illegal !== 1'b0) begin
         miscompares++;
         $display("FAIL illegal_flag got %b exp 0", bus.insn_illegal);
      end
      bus.insn_ack = 1'b1;
      step();
      bus.insn_ack = 1'b0;
      vectors++;
      if (bus.mem_rd !== 1'b1 || bus.mem_addr !== 16'h0202 || bus.insn_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL illegal_resume got rd=%b addr=%h v=%b exp 1 0202 0",
                  bus.mem_rd, bus.mem_addr, bus.insn_valid);
      end
`endif
   endtask

   task automatic test_wrap();
      mem[16'hFFFF] = 8'h00;
      load_pc(16'hFFFF);
      step();
      vectors++;
      if (bus.pc !== 16'h0000 || bus.mem_addr !== 16'h0000) begin
         miscompares++;
         $display("FAIL wrap_pc got pc=%h addr=%h exp 0000 0000", bus.pc, bus.mem_addr);
      end
      step();
      vectors++;
      if (bus.insn_valid !== 1'b1 || bus.insn_group !== G_ILLEGAL ||
          bus.insn_opcode !== 16'h0000 || bus.insn_len !== 2'd1) begin
         miscompares++;
         $display("FAIL wrap_nop got v=%b g=%h op=%h l=%0d exp 1 ff 0000 1",
                  bus.insn_valid, bus.insn_group, bus.insn_opcode, bus.insn_len);
      end
      bus.insn_ack = 1'b1;
      step();
      bus.insn_ack = 1'b0;
   endtask

   task automatic test_async_reset();
      mem[16'h0600] = 8'h3E;
      load_pc(16'h0600);
      step(); // DECODE, one byte held
      #2 reset = 1'b1;
      #1;
      vectors++;
      if (bus.pc !== 16'h0000 || bus.mem_rd !== 1'b0 || bus.dec_instr_len !== 2'd0 ||
          bus.dec_instr !== 16'h0000 || bus.insn_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL async_reset got pc=%h rd=%b dl=%0d di=%h v=%b exp 0000 0 0 0000 0",
                  bus.pc, bus.mem_rd, bus.dec_instr_len, bus.dec_instr, bus.insn_valid);
      end
      step();
      reset = 1'b0;
      step();
      vectors++;
      if (bus.mem_rd !== 1'b1 || bus.mem_addr !== 16'h0000) begin
         miscompares++;
         $display("FAIL reset_restart got rd=%b addr=%h exp 1 0000", bus.mem_rd, bus.mem_addr);
      end
   endtask

   initial begin
      vectors       = 0;
      miscompares   = 0;
      reset         = 1'b1;
      bus.mem_ready = 1'b1;
      bus.insn_ack  = 1'b0;
      bus.pc_load   = 1'b0;
      bus.pc_in     = 16'h0000;
      for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
      test_reset();
      test_single_byte();
      test_two_byte();
      test_pc_load_discard();
      test_wait_ack();
      test_back_to_back();
      test_illegal();
      test_wrap();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
